// File: rtl/encoder.sv
// -----------------------------------------------------------------------------
// encoder
//   Registered one-hot-to-binary encoder. A 2**OUT_SIZE-bit one-hot vector is
//   turned into its OUT_SIZE-bit index, one cycle later. The valid output flags
//   that at least one bit was set. The err output flags that more than one bit
//   was set; in that case the highest set bit wins.
//
//   Optional feature macro: ENCODER_ENABLE_EN
//     defined   -> an 'enable' input is added. With enable low the outputs
//                  hold their values. Reset still overrides enable.
//     undefined -> no enable port; the registers load every cycle.
// -----------------------------------------------------------------------------
module encoder #(
  parameter int OUT_SIZE = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [(1<<OUT_SIZE)-1:0]   in,
  output logic [OUT_SIZE-1:0]        out,
  output logic                       valid,
  output logic                       err
`ifdef ENCODER_ENABLE_EN
  ,
  input  logic                       enable
`endif
);

  localparam int IN_SIZE = 1 << OUT_SIZE;

  logic [OUT_SIZE-1:0] idx_next;
  logic                any_next;
  logic                multi_next;
  logic                load;

`ifdef ENCODER_ENABLE_EN
  assign load = enable;
`else
  assign load = 1'b1;
`endif

  // Scan the input from LSB to MSB. A later set bit overwrites the index, so
  // the highest set bit has priority. A second set bit raises the multi-hot flag.
  always_comb begin
    // NOTE: every variable gets a default before the loop. Without that, a
    // path that leaves one unassigned would infer a latch.
    idx_next   = '0;
    any_next   = 1'b0;
    multi_next = 1'b0;
    for (int k = 0; k < IN_SIZE; k++) begin
      if (in[k]) begin
        multi_next = multi_next | any_next;
        any_next   = 1'b1;
        idx_next   = OUT_SIZE'(k);
      end
    end
  end

  // Output registers: synchronous reset has priority, then a conditional load.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments. All registers then
    // sample the pre-edge values, which avoids ordering races between blocks.
    if (rst) begin
      out   <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else if (load) begin
      out   <= idx_next;
      valid <= any_next;
      err   <= multi_next;
    end
  end

endmodule

// File: tb/tb_encoder.sv
// -----------------------------------------------------------------------------
// tb_encoder
//   Self-checking bench for encoder (OUT_SIZE = 4).
//
//   The reference model works from the vector's value:
//     - it counts the set bits;
//     - it takes floor(log2(value)) as the index of the highest set bit.
//   The bench holds the expected register contents itself. When the optional
//   enable exists, a cycle with enable low leaves those expected values as
//   they were.
// -----------------------------------------------------------------------------
module tb_encoder;

  localparam int OUT_SIZE = 4;
  localparam int IN_SIZE  = 1 << OUT_SIZE;

  logic                clk;
  logic                rst;
  logic [IN_SIZE-1:0]  in;
  logic [OUT_SIZE-1:0] out;
  logic                valid;
  logic                err;
  logic                enable;

  int n_tests;
  int n_fail;

  // Expected register contents, kept by the bench.
  int exp_out;
  int exp_valid;
  int exp_err;

  encoder #(.OUT_SIZE(OUT_SIZE)) dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .out    (out),
    .valid  (valid),
    .err    (err)
`ifdef ENCODER_ENABLE_EN
    ,
    .enable (enable)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_tests++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: popcount plus integer log2 of the vector's value.
  function automatic void model(input logic [IN_SIZE-1:0] v,
                                output int m_out, output int m_valid,
                                output int m_err);
    longint unsigned x;
    int ones;
    ones    = $countones(v);
    m_valid = (ones > 0) ? 1 : 0;
    m_err   = (ones > 1) ? 1 : 0;
    m_out   = 0;
    x       = longint'(v);
    while (x > 1) begin
      x = x / 2;
      m_out++;
    end
  endfunction

  task automatic check_outs(input string tag);
    check({tag, ".out"},   32'(out),   32'(exp_out));
    check({tag, ".valid"}, 32'(valid), 32'(exp_valid));
    check({tag, ".err"},   32'(err),   32'(exp_err));
  endtask

  // Drive one cycle. Inputs change 1 time unit after the rising edge, and the
  // outputs are sampled 1 time unit after the next rising edge.
  task automatic cycle(input logic [IN_SIZE-1:0] v, input logic en,
                       input string tag);
    int m_out, m_valid, m_err;
    in     = v;
    enable = en;
    @(posedge clk);
    #1;
`ifdef ENCODER_ENABLE_EN
    if (en) begin
`else
    begin
`endif
      model(v, m_out, m_valid, m_err);
      exp_out   = m_out;
      exp_valid = m_valid;
      exp_err   = m_err;
    end
    check_outs(tag);
  endtask

  task automatic reset_cycle(input logic [IN_SIZE-1:0] v, input logic en,
                             input string tag);
    in     = v;
    enable = en;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    exp_out   = 0;
    exp_valid = 0;
    exp_err   = 0;
    check_outs(tag);
  endtask

  initial begin
    logic [IN_SIZE-1:0] v;
    logic               en;
    int                 mode;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    enable    = 1'b1;
    in        = '0;
    exp_out   = 0;
    exp_valid = 0;
    exp_err   = 0;
    #1;

    // Reset state, with a non-zero input present.
    reset_cycle(16'hFFFF, 1'b1, "reset");

    // Walking one across every bit position, including the MSB (all ones).
    for (int k = 0; k < IN_SIZE; k++) begin
      v = '0;
      v[k] = 1'b1;
      cycle(v, 1'b1, $sformatf("walk%0d", k));
    end

    // All-zero input.
    cycle(16'h0000, 1'b1, "zero");

    // Multi-hot input: the highest set bit wins and err is raised.
    cycle(16'h0012, 1'b1, "multi_0012");
    cycle(16'h8001, 1'b1, "multi_8001");
    cycle(16'hFFFF, 1'b1, "multi_ffff");

    // Reset mid-operation, then recovery on the following edge.
    cycle(16'h0004, 1'b1, "pre_rst");
    reset_cycle(16'h0080, 1'b1, "mid_rst");
    cycle(16'h0080, 1'b1, "post_rst");

`ifdef ENCODER_ENABLE_EN
    // Outputs hold while enable is low, then load again when it rises.
    cycle(16'h0400, 1'b1, "en_load");
    cycle(16'h0002, 1'b0, "en_hold");
    cycle(16'h0002, 1'b1, "en_reload");
    // Reset overrides enable low.
    reset_cycle(16'h0100, 1'b0, "en_rst");
`endif

    // Randomized traffic: a mix of zero, one-hot and arbitrary vectors.
    for (int i = 0; i < 300; i++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0:       v = '0;
        1:       begin v = '0; v[$urandom_range(0, IN_SIZE - 1)] = 1'b1; end
        default: v = IN_SIZE'($urandom);
      endcase
`ifdef ENCODER_ENABLE_EN
      en = ($urandom_range(0, 3) != 0);
`else
      en = 1'b1;
`endif
      if ($urandom_range(0, 49) == 0) reset_cycle(v, en, "rand_rst");
      else                            cycle(v, en, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
